// File: rtl/uart_cmd_ctrl.sv
// ============================================================================
// Module  : uart_cmd_ctrl
// Purpose : Parses SYNC/ADDR/DATA/CSUM byte frames from a UART receiver into
//           one-cycle register writes, flags checksum/range/timeout errors.
//           Optional ACK/NAK echo to UART TX when UART_CMD_ECHO_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_cmd_ctrl #(
  parameter int          ADDR_W      = 4,
  parameter int          TIMEOUT_CYC = 100000,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rx_valid,
  input  logic [7:0]        i_rx_data,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [7:0]        o_wr_data,
  output logic              o_err,
  output logic [1:0]        o_err_code,
  output logic              o_busy,
  output logic              o_tx_valid,
  output logic [7:0]        o_tx_data,
  input  logic              i_tx_ready
);

  localparam int             CNT_W      = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [8:0]     ADDR_LIMIT = 9'(1) << ADDR_W;
  localparam logic [1:0]     ERR_CSUM   = 2'b01;
  localparam logic [1:0]     ERR_RANGE  = 2'b10;
  localparam logic [1:0]     ERR_TMO    = 2'b11;

  typedef enum logic [2:0] {
    S_SYNC  = 3'd0,
    S_ADDR  = 3'd1,
    S_DATA  = 3'd2,
    S_CSUM  = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  state_t           state;
  logic [7:0]       addr_byte;
  logic [7:0]       data_byte;
  logic [CNT_W-1:0] tmo_cnt;
  logic [7:0]       csum_calc;
  logic             csum_ok;
  logic             range_ok;
  logic             waiting;

  assign csum_calc = addr_byte + data_byte;
  assign csum_ok   = (csum_calc == i_rx_data);
  assign range_ok  = ({1'b0, addr_byte} < ADDR_LIMIT);
  assign waiting   = (state == S_ADDR) || (state == S_DATA) || (state == S_CSUM);
  assign o_busy    = (state != S_SYNC);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= S_SYNC;
      addr_byte  <= '0;
      data_byte  <= '0;
      tmo_cnt    <= '0;
      o_wr_en    <= 1'b0;
      o_wr_addr  <= '0;
      o_wr_data  <= '0;
      o_err      <= 1'b0;
      o_err_code <= '0;
    end else begin
      o_wr_en <= 1'b0;
      o_err   <= 1'b0;
      if (waiting && !i_rx_valid) begin
        // Inter-byte gap inside a frame; a byte on the last cycle beats the timeout.
        if (tmo_cnt == TMO_LAST) begin
          tmo_cnt    <= '0;
          o_err      <= 1'b1;
          o_err_code <= ERR_TMO;
          state      <= S_SYNC;
        end else begin
          tmo_cnt <= tmo_cnt + CNT_W'(1);
        end
      end else begin
        tmo_cnt <= '0;
        case (state)
          S_SYNC, S_WRITE: begin
            if (i_rx_valid && (i_rx_data == SYNC_BYTE)) state <= S_ADDR;
            else                                        state <= S_SYNC;
          end
          S_ADDR: begin
            addr_byte <= i_rx_data;
            state     <= S_DATA;
          end
          S_DATA: begin
            data_byte <= i_rx_data;
            state     <= S_CSUM;
          end
          S_CSUM: begin
            if (!csum_ok) begin
              o_err      <= 1'b1;
              o_err_code <= ERR_CSUM;
              state      <= S_SYNC;
            end else if (!range_ok) begin
              o_err      <= 1'b1;
              o_err_code <= ERR_RANGE;
              state      <= S_SYNC;
            end else begin
              o_wr_en   <= 1'b1;
              o_wr_addr <= addr_byte[ADDR_W-1:0];
              o_wr_data <= data_byte;
              state     <= S_WRITE;
            end
          end
          default: state <= S_SYNC;
        endcase
      end
    end
  end

`ifdef UART_CMD_ECHO_EN
  localparam logic [7:0] ECHO_ACK = 8'h06;
  localparam logic [7:0] ECHO_NAK = 8'h15;

  // A fresh echo overrides a pending one, even if TX accepts it this cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_tx_valid <= 1'b0;
      o_tx_data  <= '0;
    end else if ((state == S_CSUM) && i_rx_valid) begin
      o_tx_valid <= 1'b1;
      o_tx_data  <= (csum_ok && range_ok) ? ECHO_ACK : ECHO_NAK;
    end else if (i_tx_ready) begin
      o_tx_valid <= 1'b0;
    end
  end
`else
  logic unused_tx_ready;
  assign unused_tx_ready = i_tx_ready;
  assign o_tx_valid      = 1'b0;
  assign o_tx_data       = 8'h00;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_cmd_ctrl.sv
// ============================================================================
// Module  : tb_uart_cmd_ctrl
// Purpose : Self-checking bench for uart_cmd_ctrl; a frame-level reference
//           model predicts every output each cycle under directed+random bytes.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_cmd_ctrl;

  localparam int         ADDR_W      = 4;
  localparam int         TIMEOUT_CYC = 20;
  localparam logic [7:0] SYNC        = 8'hA5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              tx_ready = 1'b0;
  logic              wr_en, err, busy, tx_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data, tx_data;
  logic [1:0]        err_code;

  uart_cmd_ctrl #(
    .ADDR_W      (ADDR_W),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .SYNC_BYTE   (SYNC)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_rx_valid (rx_valid),
    .i_rx_data  (rx_data),
    .o_wr_en    (wr_en),
    .o_wr_addr  (wr_addr),
    .o_wr_data  (wr_data),
    .o_err      (err),
    .o_err_code (err_code),
    .o_busy     (busy),
    .o_tx_valid (tx_valid),
    .o_tx_data  (tx_data),
    .i_tx_ready (tx_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit echo_en;
  bit hold_ready = 1'b0;

  // Reference model state: bytes collected for the current frame and idle gap.
  byte unsigned      frame[$];
  int                idle = 0;
  logic              m_wr_en = 0, m_err = 0, m_busy = 0, m_tx_valid = 0;
  logic [ADDR_W-1:0] m_wr_addr = '0;
  logic [7:0]        m_wr_data = 0, m_tx_data = 0;
  logic [1:0]        m_err_code = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [7:0] a;
    int         s;
    m_wr_en = 1'b0;
    m_err   = 1'b0;
    if (rst) begin
      frame.delete();
      idle = 0;
      m_wr_addr = '0; m_wr_data = 0; m_err_code = 0;
      m_tx_valid = 0; m_tx_data = 0; m_busy = 0;
      return;
    end
    if (echo_en && tx_ready) m_tx_valid = 1'b0;
    if (rx_valid) begin
      idle = 0;
      if (frame.size() == 0) begin
        if (rx_data == SYNC) frame.push_back(rx_data);
      end else begin
        frame.push_back(rx_data);
        if (frame.size() == 4) begin
          a = frame[1];
          s = (int'(frame[1]) + int'(frame[2])) % 256;
          if (s != int'(frame[3])) begin
            m_err = 1'b1; m_err_code = 2'd1;
          end else if (int'(frame[1]) >= (1 << ADDR_W)) begin
            m_err = 1'b1; m_err_code = 2'd2;
          end else begin
            m_wr_en = 1'b1; m_wr_addr = a[ADDR_W-1:0]; m_wr_data = frame[2];
          end
          if (echo_en) begin
            m_tx_valid = 1'b1;
            m_tx_data  = m_wr_en ? 8'h06 : 8'h15;
          end
          frame.delete();
        end
      end
    end else if (frame.size() > 0) begin
      idle++;
      if (idle == TIMEOUT_CYC) begin
        m_err = 1'b1; m_err_code = 2'd3;
        frame.delete();
        idle = 0;
      end
    end
    m_busy = (frame.size() > 0) || m_wr_en;
  endtask

  task automatic cycle(input logic v, input logic [7:0] d);
    @(negedge clk);
    rx_valid = v;
    rx_data  = d;
    tx_ready = hold_ready ? 1'b0 : 1'($urandom_range(0, 1));
    model_step();
    @(posedge clk);
    #1;
    check_eq("wr_en",    32'(wr_en),    32'(m_wr_en));
    check_eq("wr_addr",  32'(wr_addr),  32'(m_wr_addr));
    check_eq("wr_data",  32'(wr_data),  32'(m_wr_data));
    check_eq("err",      32'(err),      32'(m_err));
    check_eq("err_code", 32'(err_code), 32'(m_err_code));
    check_eq("busy",     32'(busy),     32'(m_busy));
    check_eq("tx_valid", 32'(tx_valid), 32'(m_tx_valid));
    check_eq("tx_data",  32'(tx_data),  32'(m_tx_data));
    check_eq("wr_err_excl", 32'(wr_en & err), 32'd0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'($urandom));
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    idle_cycles(gap);
    cycle(1'b1, b);
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c, input int gap);
    send_byte(SYNC, gap);
    send_byte(a, gap);
    send_byte(d, gap);
    send_byte(c, gap);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle(1'b0, 8'h00);
    rst = 1'b0;
  endtask

  initial begin
`ifdef UART_CMD_ECHO_EN
    echo_en = 1'b1;
`else
    echo_en = 1'b0;
`endif
    do_reset();
    check_eq("reset_busy", 32'(busy), 32'd0);

    // Basic write, then checksum error, then wrapping checksum write.
    send_frame(8'h03, 8'h5A, 8'h5D, 0);
    check_eq("t1_wr_addr", 32'(wr_addr), 32'h3);
    idle_cycles(2);
    send_frame(8'h03, 8'h5A, 8'h00, 1);
    check_eq("t2_err_code", 32'(err_code), 32'h1);
    send_frame(8'h01, 8'hFF, 8'h00, 0);
    check_eq("t2_wr_data", 32'(wr_data), 32'hFF);
    // Address out of range.
    send_frame(8'h20, 8'h01, 8'h21, 0);
    check_eq("t3_err_code", 32'(err_code), 32'h2);

    // Timeout after ADDR, then DATA landing exactly on the timeout cycle.
    send_byte(SYNC, 2);
    send_byte(8'h03, 0);
    idle_cycles(TIMEOUT_CYC);
    check_eq("t4_err_code", 32'(err_code), 32'h3);
    check_eq("t4_busy", 32'(busy), 32'd0);
    send_byte(SYNC, 1);
    send_byte(8'h04, 0);
    send_byte(8'h11, TIMEOUT_CYC - 1);
    send_byte(8'h15, TIMEOUT_CYC - 1);
    check_eq("t4b_wr_data", 32'(wr_data), 32'h11);

    // Junk before sync, reset mid-frame, then a clean frame.
    send_byte(8'h00, 1);
    send_byte(SYNC, 0);
    send_byte(8'h07, 0);
    do_reset();
    send_frame(8'h02, 8'h40, 8'h42, 0);
    check_eq("t5_wr_addr", 32'(wr_addr), 32'h2);

    // Echo hold/overwrite with TX stalled, then release.
    hold_ready = 1'b1;
    send_frame(8'h05, 8'h10, 8'h15, 0);
    send_frame(8'h05, 8'h10, 8'h00, 0);
    idle_cycles(3);
    hold_ready = 1'b0;
    idle_cycles(4);

    // Randomized mix of good, corrupted, out-of-range, junk and stalled frames.
    for (int it = 0; it < 400; it++) begin
      logic [7:0] a, d, c;
      int         kind, gap;
      kind = $urandom_range(0, 9);
      gap  = ($urandom_range(0, 9) == 0) ? TIMEOUT_CYC - 1 + $urandom_range(0, 1)
                                        : $urandom_range(0, 3);
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
      d = 8'($urandom);
      c = a + d;
      if (kind < 2) c = c ^ 8'($urandom_range(1, 255));
      hold_ready = ($urandom_range(0, 4) == 0);
      if (kind == 8) begin
        send_byte(8'($urandom), gap);
      end else if (kind == 9) begin
        send_byte(SYNC, 0);
        send_byte(a, $urandom_range(0, 2));
        idle_cycles(gap);
      end else begin
        send_frame(a, d, c, gap);
      end
      if ($urandom_range(0, 49) == 0) do_reset();
    end
    hold_ready = 1'b0;
    idle_cycles(TIMEOUT_CYC + 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
